// File: rtl/tc_io_pkg.sv
// Shared types and constants for the TinyComp serial input path.
// The receiver carries an extra PARITY state that is only entered when TC_IN_PARITY_EN is defined.
package tc_io_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_e;

    localparam int unsigned BYTE_IDX_W           = 2;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/tc_uart_rx.sv
// UART receiver: 2-flop synchronizer, receive FSM and bit-time counter, 8N1 by default.
// Defining TC_IN_PARITY_EN switches the frame to 8E1 and adds the parity_err_o output.
module tc_uart_rx
    import tc_io_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rxd_i,
    output logic       byte_vld_o,
    output logic [7:0] byte_o,
`ifdef TC_IN_PARITY_EN
    output logic       parity_err_o,
`endif
    output logic       frame_err_o
);

    localparam int unsigned   CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_ok;
`ifdef TC_IN_PARITY_EN
    logic             par_bad_q, par_bad_d;
`endif

    // Synchronizer and edge history idle high so reset never looks like a start edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
`ifdef TC_IN_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            rx_meta_q <= rxd_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
`ifdef TC_IN_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

`ifdef TC_IN_PARITY_EN
    assign byte_ok = ~par_bad_q;
`else
    assign byte_ok = 1'b1;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_vld_o   = 1'b0;
        frame_err_o  = 1'b0;
`ifdef TC_IN_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_o = 1'b0;
`endif
        case (state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = RX_START;
                    cnt_d   = HALF_M1;
                end
            end
            RX_START: begin
                if (cnt_q == '0) begin
                    if (!rx_sync_q) begin
                        state_d = RX_DATA;
                        cnt_d   = FULL_M1;
                        bit_d   = '0;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    cnt_d   = FULL_M1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef TC_IN_PARITY_EN
                        state_d = RX_PARITY;
`else
                        state_d = RX_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef TC_IN_PARITY_EN
            RX_PARITY: begin
                if (cnt_q == '0) begin
                    // Even parity: data bits plus parity bit must XOR to zero.
                    par_bad_d    = rx_sync_q ^ (^shift_q);
                    parity_err_o = rx_sync_q ^ (^shift_q);
                    state_d      = RX_STOP;
                    cnt_d        = FULL_M1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif
            RX_STOP: begin
                if (cnt_q == '0) begin
                    if (rx_sync_q) begin
                        byte_vld_o = byte_ok;
                        state_d    = RX_IDLE;
                    end else begin
                        frame_err_o = 1'b1;
                        state_d     = RX_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RX_BREAK: begin
                if (rx_sync_q) begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_o = shift_q;

endmodule

// File: rtl/tc_in_port.sv
// TinyComp input port: UART bytes assembled into little-endian 32-bit words and queued in a FIFO.
// TC_IN_PARITY_EN selects 8E1 framing and exposes the ParityErr pulse.
module tc_in_port
    import tc_io_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned DEPTH_LOG2   = 4
) (
    input  logic        Ph0,
    input  logic        Reset,
    input  logic        RxD,
    input  logic        InStrobe,
    output logic [31:0] InData,
    output logic        InRdy,
    output logic        Overrun,
`ifdef TC_IN_PARITY_EN
    output logic        ParityErr,
`endif
    output logic        FrameErr
);

    localparam int unsigned PTR_W = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic                  byte_vld;
    logic [7:0]            rx_byte;
    logic                  frame_err;
`ifdef TC_IN_PARITY_EN
    logic                  parity_err;
    logic                  parity_err_q;
`endif

    tc_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk_i       (Ph0),
        .rst_i       (Reset),
        .rxd_i       (RxD),
        .byte_vld_o  (byte_vld),
        .byte_o      (rx_byte),
`ifdef TC_IN_PARITY_EN
        .parity_err_o(parity_err),
`endif
        .frame_err_o (frame_err)
    );

    logic [BYTE_IDX_W-1:0] k_q, k_d;
    logic [23:0]           word_q, word_d;
    logic                  push_req;
    logic [31:0]           push_word;

    // Only the low three bytes are stored; the fourth goes straight into the FIFO.
    always_comb begin
        k_d       = k_q;
        word_d    = word_q;
        push_req  = 1'b0;
        push_word = {rx_byte, word_q};
        if (byte_vld) begin
            if (k_q == '1) begin
                push_req = 1'b1;
                k_d      = '0;
            end else begin
                k_d = k_q + BYTE_IDX_W'(1);
                case (k_q)
                    2'd0:    word_d[7:0]   = rx_byte;
                    2'd1:    word_d[15:8]  = rx_byte;
                    default: word_d[23:16] = rx_byte;
                endcase
            end
        end
    end

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [31:0]      mem_q [DEPTH];
    logic             empty, full, pop, push_ok;
    logic             overrun_q, frame_err_q;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                     (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    assign pop     = InStrobe && !empty;
    assign push_ok = push_req && (!full || pop);

    always_ff @(posedge Ph0 or posedge Reset) begin
        if (Reset) begin
            k_q          <= '0;
            word_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef TC_IN_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            k_q          <= k_d;
            word_q       <= word_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            overrun_q    <= push_req && full && !pop;
            frame_err_q  <= frame_err;
`ifdef TC_IN_PARITY_EN
            parity_err_q <= parity_err;
`endif
        end
    end

    always_ff @(posedge Ph0) begin
        if (push_ok) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_word;
    end

    assign InData   = empty ? '0 : mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    assign InRdy    = !empty;
    assign Overrun  = overrun_q;
    assign FrameErr = frame_err_q;
`ifdef TC_IN_PARITY_EN
    assign ParityErr = parity_err_q;
`endif

endmodule

// File: tb/tb_tc_in_port.sv
// Directed bench for tc_in_port with CLKS_PER_BIT=16, DEPTH_LOG2=2; covers TC_IN_PARITY_EN builds too.
module tb_tc_in_port;

    localparam int CPB = 16;
    localparam int GAP = 8;
`ifdef TC_IN_PARITY_EN
    localparam int PUSH_OFS = 170;
`else
    localparam int PUSH_OFS = 154;
`endif

    logic        Ph0 = 1'b0;
    logic        Reset, RxD, InStrobe;
    logic [31:0] InData;
    logic        InRdy, Overrun, FrameErr;
`ifdef TC_IN_PARITY_EN
    logic        ParityErr;
`endif

    tc_in_port #(
        .CLKS_PER_BIT(CPB),
        .DEPTH_LOG2  (2)
    ) dut (
        .Ph0     (Ph0),
        .Reset   (Reset),
        .RxD     (RxD),
        .InStrobe(InStrobe),
        .InData  (InData),
        .InRdy   (InRdy),
        .Overrun (Overrun),
`ifdef TC_IN_PARITY_EN
        .ParityErr(ParityErr),
`endif
        .FrameErr(FrameErr)
    );

    always #5 Ph0 = ~Ph0;

    int total = 0;
    int bad   = 0;
    int ovr_n = 0;
    int fe_n  = 0;
    int pe_n  = 0;

    always @(negedge Ph0) begin
        if (Overrun === 1'b1)  ovr_n++;
        if (FrameErr === 1'b1) fe_n++;
`ifdef TC_IN_PARITY_EN
        if (ParityErr === 1'b1) pe_n++;
`endif
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input logic par_flip);
        RxD = 1'b0;
        repeat (CPB) @(negedge Ph0);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            repeat (CPB) @(negedge Ph0);
        end
`ifdef TC_IN_PARITY_EN
        RxD = (^b) ^ par_flip;
        repeat (CPB) @(negedge Ph0);
`endif
        RxD = stop;
        repeat (CPB) @(negedge Ph0);
        RxD = 1'b1;
        repeat (GAP) @(negedge Ph0);
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0],   1'b1, 1'b0);
        send_byte(w[15:8],  1'b1, 1'b0);
        send_byte(w[23:16], 1'b1, 1'b0);
        send_byte(w[31:24], 1'b1, 1'b0);
    endtask

    task automatic pop_one();
        InStrobe = 1'b1;
        @(negedge Ph0);
        InStrobe = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        @(negedge Ph0);
        Reset = 1'b0;
        repeat (2) @(negedge Ph0);
    endtask

    typedef struct {
        logic [7:0]  b0, b1, b2, b3;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [4];
    logic [31:0] ow   [5];
    int          ovr0, fe0, pe0;

    initial begin
        vecs[0] = '{8'h78, 8'h56, 8'h34, 8'h12, 32'h12345678};
        vecs[1] = '{8'hFF, 8'h00, 8'hA5, 8'h5A, 32'h5AA500FF};
        vecs[2] = '{8'h01, 8'h80, 8'h7F, 8'hFE, 32'hFE7F8001};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 8'h00, 32'h00000000};
        ow[0] = 32'h11223344; ow[1] = 32'h55667788; ow[2] = 32'h99AABBCC;
        ow[3] = 32'hDDEEFF00; ow[4] = 32'hCAFEF00D;

        Reset = 1'b1; RxD = 1'b1; InStrobe = 1'b0;
        repeat (3) @(negedge Ph0);
        chk("rst_indata",   InData,   32'h0);
        chk("rst_inrdy",    {31'b0, InRdy},    32'h0);
        chk("rst_overrun",  {31'b0, Overrun},  32'h0);
        chk("rst_frameerr", {31'b0, FrameErr}, 32'h0);
        Reset = 1'b0;
        repeat (4) @(negedge Ph0);

        for (int v = 0; v < 4; v++) begin
            send_byte(vecs[v].b0, 1'b1, 1'b0);
            send_byte(vecs[v].b1, 1'b1, 1'b0);
            send_byte(vecs[v].b2, 1'b1, 1'b0);
            send_byte(vecs[v].b3, 1'b1, 1'b0);
            chk($sformatf("vec%0d_rdy", v), {31'b0, InRdy}, 32'h1);
            chk($sformatf("vec%0d_data", v), InData, vecs[v].exp);
            pop_one();
            chk($sformatf("vec%0d_rdy_after_pop", v), {31'b0, InRdy}, 32'h0);
            chk($sformatf("vec%0d_data_after_pop", v), InData, 32'h0);
        end
        chk("no_spurious_overrun", ovr_n, 0);
        chk("no_spurious_frameerr", fe_n, 0);

        // Five words into a four-deep FIFO with no pops.
        do_reset();
        ovr0 = ovr_n;
        for (int w = 0; w < 5; w++) send_word(ow[w]);
        chk("overrun_once", ovr_n - ovr0, 1);
        for (int w = 0; w < 4; w++) begin
            chk($sformatf("ovr_rdy%0d", w), {31'b0, InRdy}, 32'h1);
            chk($sformatf("ovr_data%0d", w), InData, ow[w]);
            pop_one();
        end
        chk("ovr_drained", {31'b0, InRdy}, 32'h0);

        // Full FIFO, fifth word pushed in the same cycle as a pop.
        do_reset();
        ovr0 = ovr_n;
        for (int w = 0; w < 4; w++) send_word(ow[w]);
        send_byte(ow[4][7:0],   1'b1, 1'b0);
        send_byte(ow[4][15:8],  1'b1, 1'b0);
        send_byte(ow[4][23:16], 1'b1, 1'b0);
        fork
            send_byte(ow[4][31:24], 1'b1, 1'b0);
            begin
                repeat (PUSH_OFS) @(negedge Ph0);
                InStrobe = 1'b1;
                @(negedge Ph0);
                InStrobe = 1'b0;
            end
        join
        chk("simul_no_overrun", ovr_n - ovr0, 0);
        for (int w = 1; w < 5; w++) begin
            chk($sformatf("simul_data%0d", w), InData, ow[w]);
            pop_one();
        end
        chk("simul_drained", {31'b0, InRdy}, 32'h0);

        // Framing error in the middle of a word; k keeps its position.
        do_reset();
        fe0 = fe_n;
        send_byte(8'h11, 1'b1, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        chk("frameerr_pulse", fe_n - fe0, 1);
        chk("frameerr_no_word", {31'b0, InRdy}, 32'h0);
        send_byte(8'hAA, 1'b1, 1'b0);
        send_byte(8'hBB, 1'b1, 1'b0);
        send_byte(8'hCC, 1'b1, 1'b0);
        chk("frameerr_word_rdy", {31'b0, InRdy}, 32'h1);
        chk("frameerr_word_data", InData, 32'hCCBBAA11);
        pop_one();

        // Short low glitch is a false start.
        do_reset();
        fe0 = fe_n;
        RxD = 1'b0;
        repeat (3) @(negedge Ph0);
        RxD = 1'b1;
        repeat (40) @(negedge Ph0);
        chk("glitch_no_word", {31'b0, InRdy}, 32'h0);
        chk("glitch_no_err", fe_n - fe0, 0);
        send_word(32'hDEADBEEF);
        chk("glitch_word", InData, 32'hDEADBEEF);
        pop_one();
        chk("glitch_drained", {31'b0, InRdy}, 32'h0);

        // Reset discards a partial word.
        send_byte(8'h99, 1'b1, 1'b0);
        send_byte(8'h88, 1'b1, 1'b0);
        do_reset();
        send_word(32'h0BADF00D);
        chk("rst_partial_rdy", {31'b0, InRdy}, 32'h1);
        chk("rst_partial_data", InData, 32'h0BADF00D);
        pop_one();
        chk("rst_partial_one_word", {31'b0, InRdy}, 32'h0);

`ifdef TC_IN_PARITY_EN
        do_reset();
        pe0 = pe_n;
        send_byte(8'h01, 1'b1, 1'b1);
        chk("parity_pulse", pe_n - pe0, 1);
        send_word(32'h44332211);
        chk("parity_word_rdy", {31'b0, InRdy}, 32'h1);
        chk("parity_word_data", InData, 32'h44332211);
        pop_one();
`else
        pe0 = pe_n;
        chk("parity_absent", pe0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
